intel_vvp_exposure_fusion_core: RTL and testbench

- Pixel datapath of the Exposure Fusion IP, directly downstream of the CPU register block.
- Consumes that block's r_vid_* controls (output mode, black level, exposure ratio, threshold) on main_clock.
- Merges co-sited long- and short-exposure pixels into one extended-range pixel stream.
- Single-clock, 3-stage pipeline with valid/ready flow control; control values are latched per frame.

---
 rtl/intel_vvp_exposure_fusion_core.sv | 255 +++++++++++++++++++++++++
 tb/tb_intel_vvp_exposure_fusion_core.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/intel_vvp_exposure_fusion_core.sv
`default_nettype none
// ============================================================================
// Module      : intel_vvp_exposure_fusion_core
// Description : Exposure fusion pixel datapath. Merges co-sited long- and
//               short-exposure pixels into one extended-range pixel using a
//               3-stage valid/ready pipeline. Output mode, black level,
//               exposure ratio and threshold are captured on each accepted
//               start-of-frame beat and travel with every beat of the frame.
//               Optional macro EXPOSURE_FUSION_STATS_EN adds the
//               stat_short_count port (per-frame count of short selections).
// Revision    : 1.0 - initial release
// ============================================================================
module intel_vvp_exposure_fusion_core #(
    parameter int BPS     = 12,
    parameter int BPS_OUT = BPS + 5
) (
    input  logic               main_clock,
    input  logic               main_reset_n,
    input  logic [1:0]         r_vid_output_mode,
    input  logic [15:0]        r_vid_black_level,
    input  logic [16:0]        r_vid_exposure_ratio,
    input  logic [15:0]        r_vid_threshold,
    input  logic               din_valid,
    output logic               din_ready,
    input  logic [BPS-1:0]     din_long,
    input  logic [BPS-1:0]     din_short,
    input  logic               din_sop,
    input  logic               din_eop,
    output logic               dout_valid,
    input  logic               dout_ready,
    output logic [BPS_OUT-1:0] dout_data,
    output logic               dout_sop,
    output logic               dout_eop
`ifdef EXPOSURE_FUSION_STATS_EN
    ,
    output logic [31:0]        stat_short_count
`endif
);

    // Scaled-short width and full product width of short * ratio (+ rounding).
    localparam int c_SS_W   = BPS + 5;
    localparam int c_PROD_W = BPS + 17;

    // ------------------------------------------------------------------------
    // Flow control: one enable moves every stage together.
    // ------------------------------------------------------------------------
    logic w_en;
    logic w_accept;
    logic w_load_ctl;

    assign w_en       = dout_ready || !dout_valid;
    assign din_ready  = w_en;
    assign w_accept   = din_valid && w_en;
    assign w_load_ctl = w_accept && din_sop;

    // ------------------------------------------------------------------------
    // Per-frame control latch. The sop beat itself must already see the new
    // values, so the effective controls bypass the latch on that beat.
    // ------------------------------------------------------------------------
    logic [1:0]  r_ctl_mode;
    logic [15:0] r_ctl_black_level;
    logic [16:0] r_ctl_ratio;
    logic [15:0] r_ctl_threshold;

    logic [1:0]  w_mode;
    logic [15:0] w_black_level;
    logic [16:0] w_ratio;
    logic [15:0] w_threshold;

    assign w_mode        = w_load_ctl ? r_vid_output_mode    : r_ctl_mode;
    assign w_black_level = w_load_ctl ? r_vid_black_level    : r_ctl_black_level;
    assign w_ratio       = w_load_ctl ? r_vid_exposure_ratio : r_ctl_ratio;
    assign w_threshold   = w_load_ctl ? r_vid_threshold      : r_ctl_threshold;

    // Capture the frame's control values on every accepted sop beat.
    always_ff @(posedge main_clock or negedge main_reset_n) begin
        if (!main_reset_n) begin
            r_ctl_mode        <= '0;
            r_ctl_black_level <= '0;
            r_ctl_ratio       <= '0;
            r_ctl_threshold   <= '0;
        end else if (w_load_ctl) begin
            r_ctl_mode        <= r_vid_output_mode;
            r_ctl_black_level <= r_vid_black_level;
            r_ctl_ratio       <= r_vid_exposure_ratio;
            r_ctl_threshold   <= r_vid_threshold;
        end
    end

    // ------------------------------------------------------------------------
    // Stage 1: black-level subtraction with clamp at zero. The compare is done
    // at 17 bits so a 16-bit black level above any BPS-bit pixel clamps.
    // ------------------------------------------------------------------------
    logic [16:0]    w_long_ext;
    logic [16:0]    w_short_ext;
    logic [16:0]    w_bl_ext;
    logic [16:0]    w_long_sub;
    logic [16:0]    w_short_sub;
    logic [BPS-1:0] w_l;
    logic [BPS-1:0] w_s;

    assign w_long_ext  = 17'(din_long);
    assign w_short_ext = 17'(din_short);
    assign w_bl_ext    = 17'(w_black_level);
    assign w_long_sub  = w_long_ext - w_bl_ext;
    assign w_short_sub = w_short_ext - w_bl_ext;
    assign w_l = (w_bl_ext >= w_long_ext)  ? '0 : w_long_sub[BPS-1:0];
    assign w_s = (w_bl_ext >= w_short_ext) ? '0 : w_short_sub[BPS-1:0];

    logic           r_s1_valid;
    logic           r_s1_sop;
    logic           r_s1_eop;
    logic [BPS-1:0] r_s1_l;
    logic [BPS-1:0] r_s1_s;
    logic [16:0]    r_s1_ratio;
    logic [15:0]    r_s1_threshold;
    logic [1:0]     r_s1_mode;

    // Stage 1 register: clamped pixels plus the controls this beat uses.
    always_ff @(posedge main_clock or negedge main_reset_n) begin
        if (!main_reset_n) begin
            r_s1_valid     <= 1'b0;
            r_s1_sop       <= 1'b0;
            r_s1_eop       <= 1'b0;
            r_s1_l         <= '0;
            r_s1_s         <= '0;
            r_s1_ratio     <= '0;
            r_s1_threshold <= '0;
            r_s1_mode      <= '0;
        end else if (w_en) begin
            r_s1_valid <= din_valid;
            r_s1_sop   <= din_valid && din_sop;
            r_s1_eop   <= din_valid && din_eop;
            if (din_valid) begin
                r_s1_l         <= w_l;
                r_s1_s         <= w_s;
                r_s1_ratio     <= w_ratio;
                r_s1_threshold <= w_threshold;
                r_s1_mode      <= w_mode;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stage 2: scale short by the 5.12 ratio with round-half-up. The product
    // plus 2048 cannot overflow c_PROD_W bits, and the shifted result always
    // fits c_SS_W bits, so no saturation is needed.
    // ------------------------------------------------------------------------
    logic [c_PROD_W-1:0] w_prod;
    logic [c_SS_W-1:0]   w_ss;
    logic                w_sel;

    assign w_prod = c_PROD_W'(r_s1_s) * c_PROD_W'(r_s1_ratio) + c_PROD_W'(2048);
    assign w_ss   = c_SS_W'(w_prod >> 12);
    assign w_sel  = 17'(r_s1_l) >= 17'(r_s1_threshold);

    logic              r_s2_valid;
    logic              r_s2_sop;
    logic              r_s2_eop;
    logic [BPS-1:0]    r_s2_l;
    logic [c_SS_W-1:0] r_s2_ss;
    logic              r_s2_sel;
    logic [1:0]        r_s2_mode;

    // Stage 2 register: long level, scaled short and the selection decision.
    always_ff @(posedge main_clock or negedge main_reset_n) begin
        if (!main_reset_n) begin
            r_s2_valid <= 1'b0;
            r_s2_sop   <= 1'b0;
            r_s2_eop   <= 1'b0;
            r_s2_l     <= '0;
            r_s2_ss    <= '0;
            r_s2_sel   <= 1'b0;
            r_s2_mode  <= '0;
        end else if (w_en) begin
            r_s2_valid <= r_s1_valid;
            r_s2_sop   <= r_s1_sop;
            r_s2_eop   <= r_s1_eop;
            if (r_s1_valid) begin
                r_s2_l    <= r_s1_l;
                r_s2_ss   <= w_ss;
                r_s2_sel  <= w_sel;
                r_s2_mode <= r_s1_mode;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stage 3: output mux by the beat's latched mode.
    // ------------------------------------------------------------------------
    logic [BPS_OUT-1:0] w_out;

    // Select the output pixel for the beat leaving stage 2.
    always_comb begin
        w_out = '0;
        case (r_s2_mode)
            2'd0:    w_out = r_s2_sel ? BPS_OUT'(r_s2_ss) : BPS_OUT'(r_s2_l);
            2'd1:    w_out = BPS_OUT'(r_s2_l);
            2'd2:    w_out = BPS_OUT'(r_s2_ss);
            default: w_out = r_s2_sel ? '1 : '0;
        endcase
    end

    // Stage 3 register: drives the output interface directly.
    always_ff @(posedge main_clock or negedge main_reset_n) begin
        if (!main_reset_n) begin
            dout_valid <= 1'b0;
            dout_sop   <= 1'b0;
            dout_eop   <= 1'b0;
            dout_data  <= '0;
        end else if (w_en) begin
            dout_valid <= r_s2_valid;
            dout_sop   <= r_s2_sop;
            dout_eop   <= r_s2_eop;
            if (r_s2_valid) begin
                dout_data <= w_out;
            end
        end
    end

`ifdef EXPOSURE_FUSION_STATS_EN
    // ------------------------------------------------------------------------
    // Short-selection statistics, counted on beats leaving the pipeline.
    // ------------------------------------------------------------------------
    logic        r_s3_sel;
    logic [31:0] r_stat_acc;
    logic [31:0] w_stat_next;

    assign w_stat_next = (dout_sop ? 32'd0 : r_stat_acc) + 32'(r_s3_sel);

    // Keep the selection flag aligned with the beat held in stage 3.
    always_ff @(posedge main_clock or negedge main_reset_n) begin
        if (!main_reset_n) begin
            r_s3_sel <= 1'b0;
        end else if (w_en && r_s2_valid) begin
            r_s3_sel <= r_s2_sel;
        end
    end

    // Accumulate per frame; publish the total when the eop beat leaves.
    always_ff @(posedge main_clock or negedge main_reset_n) begin
        if (!main_reset_n) begin
            r_stat_acc       <= '0;
            stat_short_count <= '0;
        end else if (dout_valid && dout_ready) begin
            r_stat_acc <= w_stat_next;
            if (dout_eop) begin
                stat_short_count <= w_stat_next;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_intel_vvp_exposure_fusion_core.sv
`default_nettype none
// ============================================================================
// Module      : tb_intel_vvp_exposure_fusion_core
// Description : Self-checking bench for intel_vvp_exposure_fusion_core:
//               table vectors, hand-written corner sequences and randomized
//               traffic against a behavioural reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_intel_vvp_exposure_fusion_core;

    localparam int BPS     = 12;
    localparam int BPS_OUT = BPS + 5;

    logic               main_clock;
    logic               main_reset_n;
    logic [1:0]         r_vid_output_mode;
    logic [15:0]        r_vid_black_level;
    logic [16:0]        r_vid_exposure_ratio;
    logic [15:0]        r_vid_threshold;
    logic               din_valid;
    logic               din_ready;
    logic [BPS-1:0]     din_long;
    logic [BPS-1:0]     din_short;
    logic               din_sop;
    logic               din_eop;
    logic               dout_valid;
    logic               dout_ready;
    logic [BPS_OUT-1:0] dout_data;
    logic               dout_sop;
    logic               dout_eop;
`ifdef EXPOSURE_FUSION_STATS_EN
    logic [31:0]        stat_short_count;
`endif

    intel_vvp_exposure_fusion_core #(.BPS(BPS), .BPS_OUT(BPS_OUT)) dut (
        .main_clock           (main_clock),
        .main_reset_n         (main_reset_n),
        .r_vid_output_mode    (r_vid_output_mode),
        .r_vid_black_level    (r_vid_black_level),
        .r_vid_exposure_ratio (r_vid_exposure_ratio),
        .r_vid_threshold      (r_vid_threshold),
        .din_valid            (din_valid),
        .din_ready            (din_ready),
        .din_long             (din_long),
        .din_short            (din_short),
        .din_sop              (din_sop),
        .din_eop              (din_eop),
        .dout_valid           (dout_valid),
        .dout_ready           (dout_ready),
        .dout_data            (dout_data),
        .dout_sop             (dout_sop),
        .dout_eop             (dout_eop)
`ifdef EXPOSURE_FUSION_STATS_EN
        ,
        .stat_short_count     (stat_short_count)
`endif
    );

    initial main_clock = 1'b0;
    always #5 main_clock = ~main_clock;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [BPS_OUT-1:0] data;
        bit                 sop;
        bit                 eop;
        bit                 sel;
    } exp_t;

    exp_t exp_q[$];
    int   obs_q[$];
    int   m_mode, m_bl, m_ratio, m_thr;
    int   stat_model, stat_acc;
    bit   rand_bp = 0;

    function automatic exp_t ref_beat(int lng, int sht, bit sop, bit eop);
        longint lc, sc, ss;
        exp_t   e;
        lc = (lng > m_bl) ? lng - m_bl : 0;
        sc = (sht > m_bl) ? sht - m_bl : 0;
        ss = (sc * m_ratio + 2048) / 4096;
        e.sel = (lc >= m_thr);
        case (m_mode)
            0:       e.data = BPS_OUT'(e.sel ? ss : lc);
            1:       e.data = BPS_OUT'(lc);
            2:       e.data = BPS_OUT'(ss);
            default: e.data = e.sel ? BPS_OUT'((64'd1 << BPS_OUT) - 1) : '0;
        endcase
        e.sop = sop;
        e.eop = eop;
        return e;
    endfunction

    // Present one beat (at posedge+1) and hold it until accepted.
    task automatic send_beat(input int lng, input int sht, input bit sop, input bit eop);
        bit ok;
        bit rdy;
        din_long  = BPS'(lng);
        din_short = BPS'(sht);
        din_sop   = sop;
        din_eop   = eop;
        din_valid = 1'b1;
        ok = 0;
        for (int c = 0; c < 200 && !ok; c++) begin
            @(negedge main_clock);
            rdy = din_ready;
            @(posedge main_clock);
            if (rdy) ok = 1;
        end
        if (ok) begin
            if (sop) begin
                m_mode  = int'(r_vid_output_mode);
                m_bl    = int'(r_vid_black_level);
                m_ratio = int'(r_vid_exposure_ratio);
                m_thr   = int'(r_vid_threshold);
            end
            exp_q.push_back(ref_beat(lng, sht, sop, eop));
        end else begin
            total++; bad++;
            $display("FAIL accept_timeout: got no accept, want accept within 200 cycles");
        end
        #1;
        din_valid = 1'b0;
        din_sop   = 1'b0;
        din_eop   = 1'b0;
    endtask

    task automatic set_ctl(input int mode, input int bl, input int ratio, input int thr);
        r_vid_output_mode    = 2'(mode);
        r_vid_black_level    = 16'(bl);
        r_vid_exposure_ratio = 17'(ratio);
        r_vid_threshold      = 16'(thr);
    endtask

    // Wait (bounded) for a valid output beat, observed at a negedge.
    task automatic wait_out(output bit got);
        got = 0;
        for (int c = 0; c < 12 && !got; c++) begin
            @(negedge main_clock);
            if (dout_valid) got = 1;
        end
    endtask

    task automatic drain();
        for (int c = 0; c < 300 && exp_q.size() != 0; c++) begin
            @(posedge main_clock);
            #1;
        end
        check("drain_pending", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic reset_model();
        exp_q.delete();
        obs_q.delete();
        m_mode = 0; m_bl = 0; m_ratio = 0; m_thr = 0;
        stat_model = 0; stat_acc = 0;
    endtask

    // Monitor: every output beat is compared with the model's next beat.
    always @(negedge main_clock) begin
        if (main_reset_n) begin
`ifdef EXPOSURE_FUSION_STATS_EN
            check("stat_short_count", 64'(stat_short_count), 64'(stat_model));
`endif
            if (dout_valid && dout_ready) begin
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_out: got data %0d, want no beat", dout_data);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("mon_data", 64'(dout_data), 64'(e.data));
                    check("mon_sop",  64'(dout_sop),  64'(e.sop));
                    check("mon_eop",  64'(dout_eop),  64'(e.eop));
                    obs_q.push_back(int'(dout_data));
                    stat_acc = (e.sop ? 0 : stat_acc) + (e.sel ? 1 : 0);
                    if (e.eop) stat_model = stat_acc;
                end
            end
        end
    end

    // Random downstream backpressure while rand_bp is set.
    initial begin
        forever begin
            @(posedge main_clock);
            #1;
            if (rand_bp) dout_ready = ($urandom_range(0, 3) != 0);
        end
    end

    typedef struct {
        int mode; int bl; int ratio; int thr; int lng; int sht; int exp_data;
    } vec_t;

    vec_t vecs[15];

    initial begin
        bit got;
        int rl[10];
        int expv[5];

        vecs[0]  = '{0, 64, 65536, 3000, 1000, 100, 936};
        vecs[1]  = '{0, 64, 65536, 3000, 4000, 300, 3776};
        vecs[2]  = '{2, 0, 131071, 0, 0, 4095, 131039};
        vecs[3]  = '{2, 200, 131071, 0, 0, 150, 0};
        vecs[4]  = '{1, 64, 65536, 3000, 4000, 300, 3936};
        vecs[5]  = '{3, 64, 65536, 3000, 4000, 300, 131071};
        vecs[6]  = '{3, 64, 65536, 3000, 1000, 300, 0};
        vecs[7]  = '{0, 0, 4096, 1000, 1000, 100, 100};
        vecs[8]  = '{0, 0, 4096, 1001, 1000, 100, 1000};
        vecs[9]  = '{2, 0, 2048, 0, 0, 1, 1};
        vecs[10] = '{2, 0, 2048, 0, 0, 3, 2};
        vecs[11] = '{2, 0, 2047, 0, 0, 1, 0};
        vecs[12] = '{1, 5000, 4096, 0, 4095, 0, 0};
        vecs[13] = '{1, 4095, 4096, 0, 4095, 0, 0};
        vecs[14] = '{1, 4094, 4096, 0, 4095, 0, 1};

        // ---------- reset state ----------
        reset_model();
        main_reset_n = 1'b0;
        din_valid = 1'b0; din_long = '0; din_short = '0; din_sop = 1'b0; din_eop = 1'b0;
        dout_ready = 1'b1;
        set_ctl(0, 0, 0, 0);
        repeat (3) @(posedge main_clock);
        #1;
        check("rst_dout_valid", 64'(dout_valid), 64'd0);
        check("rst_dout_data",  64'(dout_data),  64'd0);
        check("rst_dout_sop",   64'(dout_sop),   64'd0);
        check("rst_dout_eop",   64'(dout_eop),   64'd0);
        @(negedge main_clock);
        main_reset_n = 1'b1;
        @(negedge main_clock);
        check("rst_din_ready", 64'(din_ready), 64'd1);
        @(posedge main_clock);
        #1;

        // ---------- beat before first sop uses zeroed controls ----------
        set_ctl(1, 500, 4096, 4000);
        send_beat(1000, 100, 0, 0);
        wait_out(got);
        check("pre_sop_got", 64'(got), 64'd1);
        check("pre_sop_data", 64'(dout_data), 64'd0);
        @(posedge main_clock); #1;

        // ---------- table vectors (single-pixel frames) ----------
        for (int i = 0; i < 15; i++) begin
            set_ctl(vecs[i].mode, vecs[i].bl, vecs[i].ratio, vecs[i].thr);
            send_beat(vecs[i].lng, vecs[i].sht, 1, 1);
            wait_out(got);
            check($sformatf("vec%0d_got", i), 64'(got), 64'd1);
            check($sformatf("vec%0d_data", i), 64'(dout_data), 64'(vecs[i].exp_data));
            check($sformatf("vec%0d_sopeop", i), 64'({dout_sop, dout_eop}), 64'd3);
            @(posedge main_clock); #1;
        end

        // ---------- exact 3-cycle latency ----------
        set_ctl(0, 64, 65536, 3000);
        send_beat(1000, 100, 1, 1);
        for (int c = 1; c <= 3; c++) begin
            @(negedge main_clock);
            check($sformatf("latency_c%0d", c), 64'(dout_valid), 64'(c == 3));
        end
        check("latency_data", 64'(dout_data), 64'd936);
        check("latency_sop", 64'(dout_sop), 64'd1);
        @(posedge main_clock); #1;
        drain();

        // ---------- mid-frame control change ignored ----------
        obs_q.delete();
        set_ctl(0, 64, 65536, 3000);
        send_beat(1000, 0, 1, 0);
        r_vid_black_level = 16'd0;
        send_beat(1000, 0, 0, 0);
        send_beat(1000, 0, 0, 0);
        send_beat(1000, 0, 0, 1);
        send_beat(1000, 0, 1, 1);
        drain();
        expv = '{936, 936, 936, 936, 1000};
        check("midframe_count", 64'(obs_q.size()), 64'd5);
        for (int i = 0; i < 5 && i < obs_q.size(); i++)
            check($sformatf("midframe_beat%0d", i), 64'(obs_q[i]), 64'(expv[i]));

        // ---------- backpressure ----------
        obs_q.delete();
        set_ctl(1, 0, 4096, 0);
        send_beat(10, 0, 1, 0);
        send_beat(20, 0, 0, 0);
        send_beat(30, 0, 0, 1);
        dout_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge main_clock);
            check("bp_din_ready", 64'(din_ready), 64'd0);
            check("bp_hold", 64'({dout_valid, dout_sop, dout_eop, dout_data}),
                  64'({1'b1, 1'b1, 1'b0, 17'd10}));
        end
        @(posedge main_clock); #1;
        dout_ready = 1'b1;
        drain();
        check("bp_count", 64'(obs_q.size()), 64'd3);
        for (int i = 0; i < 3 && i < obs_q.size(); i++)
            check($sformatf("bp_order%0d", i), 64'(obs_q[i]), 64'((i + 1) * 10));

        // ---------- reset mid-frame ----------
        set_ctl(1, 0, 4096, 0);
        send_beat(100, 0, 1, 0);
        send_beat(200, 0, 0, 0);
        @(posedge main_clock); #1;
        check("inflight_valid", 64'(dout_valid), 64'd1);
        #2;
        main_reset_n = 1'b0;
        #1;
        check("rst_mid_valid", 64'(dout_valid), 64'd0);
        check("rst_mid_data", 64'(dout_data), 64'd0);
        reset_model();
        @(negedge main_clock);
        main_reset_n = 1'b1;
        @(posedge main_clock); #1;
        set_ctl(0, 0, 4096, 1000);
        rl = '{500, 1000, 200, 3000, 999, 1500, 0, 4095, 10, 20};
        for (int i = 0; i < 10; i++)
            send_beat(rl[i], i * 7, i == 0, i == 9);
        drain();
        check("post_rst_count", 64'(obs_q.size()), 64'd10);
`ifdef EXPOSURE_FUSION_STATS_EN
        check("stat_frame_total", 64'(stat_short_count), 64'd4);
`endif

        // ---------- randomized traffic against the model ----------
        rand_bp = 1;
        for (int f = 0; f < 60; f++) begin
            int len;
            len = $urandom_range(1, 8);
            for (int b = 0; b < len; b++) begin
                set_ctl($urandom_range(0, 3), $urandom_range(0, 4500),
                        $urandom_range(0, 131071), $urandom_range(0, 4200));
                send_beat($urandom_range(0, 4095), $urandom_range(0, 4095), b == 0, b == len - 1);
                repeat ($urandom_range(0, 2)) begin
                    @(posedge main_clock); #1;
                end
            end
        end
        rand_bp = 0;
        dout_ready = 1'b1;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
